// File: rtl/alu_word_sequencer_if.sv
// Handshake and datapath-control bundle for alu_word_sequencer.
// slave = sequencer side, master = decode/ALU/writeback side.
interface alu_word_sequencer_if #(
  parameter int MAX_WORDS = 4
);
  localparam int NW = $clog2(MAX_WORDS + 1);
  localparam int IW =
    ($clog2(MAX_WORDS) < 1) ? 1 : $clog2(MAX_WORDS);

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_opsel;
  logic          req_mode;
  logic [NW-1:0] req_nwords;

  logic [2:0]    alu_opsel;
  logic          alu_mode;
  logic          alu_cin;
  logic          alu_cout;

  logic [IW-1:0] word_idx;
  logic          res_valid;
  logic          res_ready;

  logic          busy;
  logic          done;
  logic          carry_out;

  modport slave (
    input  req_valid,
    input  req_opsel,
    input  req_mode,
    input  req_nwords,
    input  alu_cout,
    input  res_ready,
    output req_ready,
    output alu_opsel,
    output alu_mode,
    output alu_cin,
    output word_idx,
    output res_valid,
    output busy,
    output done,
    output carry_out
  );

  modport master (
    output req_valid,
    output req_opsel,
    output req_mode,
    output req_nwords,
    output alu_cout,
    output res_ready,
    input  req_ready,
    input  alu_opsel,
    input  alu_mode,
    input  alu_cin,
    input  word_idx,
    input  res_valid,
    input  busy,
    input  done,
    input  carry_out
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// Multi-precision word sequencer: issues the ALU slice once per word,
// LSW first, chaining carry. Ports: clk, rst (sync, high), bus (slave).
module alu_word_sequencer #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 4,
  localparam int NW = $clog2(MAX_WORDS + 1),
  localparam int IW =
    ($clog2(MAX_WORDS) < 1) ? 1 : $clog2(MAX_WORDS)
) (
  input logic           clk,
  input logic           rst,
  alu_word_sequencer_if.slave bus
);

  if (WIDTH < 1 || MAX_WORDS < 2) begin : g_bad_param
    $error("alu_word_sequencer: bad WIDTH/MAX_WORDS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NW-1:0] MAXW = NW'(MAX_WORDS);

  state_t        state_q, state_d;
  logic [NW-1:0] nwords_q, nwords_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cy_out_q, cy_out_d;
  logic [2:0]    opsel_q, opsel_d;
  logic          mode_q, mode_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cin_q, cin_d;

  logic [NW-1:0] req_n;
  logic          req_init;
  logic          chain;
  logic          last;
  logic          cnext;

  // Oversized requests are clamped rather than rejected.
  assign req_n = (bus.req_nwords > MAXW) ?
                 MAXW : bus.req_nwords;

  // Subtract (arith opsel 011) seeds the LSW with carry 1.
  assign req_init = ~bus.req_mode &
                    (bus.req_opsel == 3'b011);

  // Only arithmetic ops in the lower half chain carry.
  assign chain = ~mode_q & ~opsel_q[2];
  assign cnext = chain & bus.alu_cout;
  assign last  = (NW'(idx_q) == nwords_q - NW'(1));

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cy_out_d = cy_out_q;
    opsel_d  = opsel_q;
    mode_d   = mode_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cin_d    = cin_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.req_valid) begin
          opsel_d  = bus.req_opsel;
          mode_d   = bus.req_mode;
          nwords_d = req_n;
          idx_d    = '0;
          carry_d  = 1'b0;
          cy_out_d = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          if (req_n == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            rvalid_d = 1'b0;
            cin_d    = 1'b0;
          end else begin
            state_d  = RUN;
            rvalid_d = 1'b1;
            cin_d    = req_init;
          end
        end
      end
      (state_q == RUN): begin
        if (bus.res_ready) begin
          carry_d = cnext;
          idx_d   = idx_q + IW'(1);
          if (last) begin
            cy_out_d = cnext;
            state_d  = DONE;
            done_d   = 1'b1;
            rvalid_d = 1'b0;
            cin_d    = 1'b0;
          end else begin
            // Next word is never word 0, so
            // only the chained carry applies.
            cin_d = cnext;
          end
        end
      end
      (state_q == DONE): begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        rvalid_d = 1'b0;
        cin_d    = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        rvalid_d = 1'b0;
        cin_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cy_out_q <= 1'b0;
      opsel_q  <= 3'b000;
      mode_q   <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cy_out_q <= cy_out_d;
      opsel_q  <= opsel_d;
      mode_q   <= mode_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cin_q    <= cin_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.alu_opsel = opsel_q;
  assign bus.alu_mode  = mode_q;
  assign bus.alu_cin   = cin_q;
  assign bus.word_idx  = idx_q;
  assign bus.res_valid = rvalid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.carry_out = cy_out_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Self-checking bench for alu_word_sequencer: vector table,
// hand-written corner sequences and a randomized reference model.
module tb_alu_word_sequencer;

  localparam int MW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_word_sequencer_if #(.MAX_WORDS(MW)) bus ();

  alu_word_sequencer #(
    .WIDTH(8),
    .MAX_WORDS(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] opsel;
    logic       mode;
    logic [2:0] nwords;
    logic [3:0] couts;
    logic [7:0] stalls;
    logic [3:0] exp_cins;
    logic       exp_cy;
    int         exp_n;
    int         exp_done;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Spec-level model: word i sees the ALU carry of word i-1
  // for chaining ops, subtract seeds word 0 with 1.
  task automatic model(input logic [2:0] op,
                       input logic md,
                       input logic [2:0] nw,
                       input logic [3:0] couts,
                       input logic [7:0] stalls,
                       output logic [3:0] cins,
                       output logic cy,
                       output int n,
                       output int dn);
    bit chn;
    n   = (int'(nw) > MW) ? MW : int'(nw);
    chn = (md == 1'b0) && (op < 3'd4);
    cins    = '0;
    cins[0] = (md == 1'b0) && (op == 3'd3);
    for (int i = 1; i < MW; i++)
      cins[i] = chn ? couts[i-1] : 1'b0;
    cy = (n > 0 && chn) ? couts[n-1] : 1'b0;
    dn = n + 1;
    for (int i = 0; i < n; i++)
      dn += int'(stalls[2*i +: 2]);
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic md,
                        input logic [2:0] nw,
                        input logic [3:0] couts,
                        input logic [7:0] stalls,
                        input logic [3:0] exp_cins,
                        input logic exp_cy,
                        input int exp_n,
                        input int exp_done);
    int cyc;
    int w;
    int st;
    bit fin;
    @(negedge clk);
    bus.req_opsel  = op;
    bus.req_mode   = md;
    bus.req_nwords = nw;
    bus.req_valid  = 1'b1;
    bus.res_ready  = 1'b1;
    check("req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_opsel  = 3'($urandom);
    bus.req_mode   = 1'($urandom);
    bus.req_nwords = 3'($urandom);
    @(negedge clk);
    cyc = 1;
    w   = 0;
    st  = int'(stalls[1:0]);
    fin = 0;
    while (!fin && cyc < 200) begin
      bus.res_ready = 1'b1;
      if (bus.res_valid) begin
        if (w < MW) begin
          check("word_idx", bus.word_idx, w);
          check("alu_cin", bus.alu_cin, exp_cins[w]);
          check("alu_opsel", bus.alu_opsel, op);
          check("alu_mode", bus.alu_mode, md);
          bus.alu_cout = couts[w];
        end
        if (st > 0) begin
          bus.res_ready = 1'b0;
          st--;
        end else begin
          w++;
          st = (w < MW) ? int'(stalls[2*w +: 2]) : 0;
        end
      end
      if (bus.done) begin
        check("done_cycle", cyc, exp_done);
        check("carry_out", bus.carry_out, exp_cy);
        check("words_issued", w, exp_n);
        check("busy_in_done", bus.busy, 1);
        fin = 1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("done_timeout", cyc, exp_done);
  endtask

  vec_t vecs[7];

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opsel  = 3'b000;
    bus.req_mode   = 1'b0;
    bus.req_nwords = '0;
    bus.alu_cout   = 1'b0;
    bus.res_ready  = 1'b1;

    // add: couts 1,1,0 -> cin 0,1,1
    vecs[0] = '{3'b000, 1'b0, 3'd3, 4'b0011, 8'h00,
                4'b0110, 1'b0, 3, 4};
    // subtract: couts 0,1 -> cin 1,0, carry 1
    vecs[1] = '{3'b011, 1'b0, 3'd2, 4'b0010, 8'h00,
                4'b0001, 1'b1, 2, 3};
    // logic op: no carry anywhere
    vecs[2] = '{3'b011, 1'b1, 3'd4, 4'b1111, 8'h00,
                4'b0000, 1'b0, 4, 5};
    // 3 stall cycles on word 0
    vecs[3] = '{3'b000, 1'b0, 3'd2, 4'b0011, 8'h03,
                4'b0010, 1'b1, 2, 6};
    // zero words
    vecs[4] = '{3'b000, 1'b0, 3'd0, 4'b1111, 8'h00,
                4'b0000, 1'b0, 0, 1};
    // clamped 7 -> 4 words
    vecs[5] = '{3'b001, 1'b0, 3'd7, 4'b1101, 8'h00,
                4'b1010, 1'b1, 4, 5};
    // upper-half arith op does not chain
    vecs[6] = '{3'b100, 1'b0, 3'd2, 4'b1111, 8'h00,
                4'b0000, 1'b0, 2, 3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_carry_out", bus.carry_out, 0);
    check("rst_alu_opsel", bus.alu_opsel, 0);
    check("rst_alu_mode", bus.alu_mode, 0);
    check("rst_alu_cin", bus.alu_cin, 0);
    check("rst_word_idx", bus.word_idx, 0);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].opsel, vecs[i].mode, vecs[i].nwords,
             vecs[i].couts, vecs[i].stalls,
             vecs[i].exp_cins, vecs[i].exp_cy,
             vecs[i].exp_n, vecs[i].exp_done);

    // req_valid held: next accept only in IDLE after done
    @(negedge clk);
    bus.req_opsel  = 3'b000;
    bus.req_mode   = 1'b0;
    bus.req_nwords = 3'd1;
    bus.req_valid  = 1'b1;
    bus.res_ready  = 1'b1;
    bus.alu_cout   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_run", bus.res_valid, 1);
    bus.req_opsel = 3'b011;
    @(posedge clk);
    @(negedge clk);
    check("b2b_done", bus.done, 1);
    check("b2b_ready_in_done", bus.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_ready", bus.req_ready, 1);
    check("b2b_idle_busy", bus.busy, 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_accept", bus.res_valid, 1);
    check("b2b_second_opsel", bus.alu_opsel, 3'b011);
    check("b2b_second_cin", bus.alu_cin, 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_done", bus.done, 1);

    // reset mid-RUN abandons the op without a done pulse
    run_op(3'b011, 1'b0, 3'd2, 4'b0010, 8'h00,
           4'b0001, 1'b1, 2, 3);
    @(negedge clk);
    bus.req_opsel  = 3'b000;
    bus.req_mode   = 1'b0;
    bus.req_nwords = 3'd4;
    bus.req_valid  = 1'b1;
    bus.alu_cout   = 1'b1;
    bus.res_ready  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_word_idx", bus.word_idx, 1);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_done", bus.done, 0);
    end
    rst = 1'b0;
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_carry", bus.carry_out, 0);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_idx", bus.word_idx, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_no_done", bus.done, 0);
    end

    for (int it = 0; it < 60; it++) begin
      logic [2:0] op;
      logic       md;
      logic [2:0] nw;
      logic [3:0] cs;
      logic [7:0] sl;
      logic [3:0] ec;
      logic       ey;
      int         en;
      int         ed;
      op = 3'($urandom_range(0, 7));
      md = 1'($urandom_range(0, 1));
      nw = 3'($urandom_range(0, 7));
      cs = 4'($urandom);
      sl = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      model(op, md, nw, cs, sl, ec, ey, en, ed);
      run_op(op, md, nw, cs, sl, ec, ey, en, ed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
